composite_timing_gen: RTL
=========================

COMPOSITE_TIMING_GEN -- requirements
Module: composite_timing_gen

Interface
REQ-001 SHALL have parameter LINE_CYCLES, default 1716, meaning clocks per scanline (63.55 us at 27 MHz).
REQ-002 SHALL have parameter HSYNC_CYCLES, default 127, meaning sync-tip clocks per line (4.7 us).
REQ-003 SHALL have parameter ACTIVE_START, default 300, meaning the h-count of the first active clock.
REQ-004 SHALL have parameter PIXELS, default 256, meaning active pixels per line.
REQ-005 SHALL have parameter PIXEL_DIV, default 5, meaning clocks per pixel.
REQ-006 SHALL have parameter LINES, default 262, meaning lines per field.
REQ-007 SHALL have parameter ACTIVE_LINE_START, default 20, and ACTIVE_LINES, default 224, meaning the active line window.
REQ-008 SHALL have parameter VSYNC_START, default 247, and VSYNC_LINES, default 3, meaning the vertical sync line window.
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-010 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-011 SHALL have port enable, input, 1 bit: run the timing when high.
REQ-012 SHALL have port pixel_data, input, 2 bits: the requested pixel's level.
REQ-013 SHALL have port pixel_req, output, 1 bit: one-cycle request for a pixel.
REQ-014 SHALL have ports pixel_x, output, $clog2(PIXELS) bits, and pixel_y, output, $clog2(ACTIVE_LINES) bits: the requested pixel's coordinates.
REQ-015 SHALL have ports output_450ohm and output_900ohm, output, 1 bit each: the resistor-DAC drive.
REQ-016 SHALL have port frame_start, output, 1 bit: one-cycle marker.

Function
REQ-017 SHALL keep h counter 0..LINE_CYCLES-1 and line counter 0..LINES-1, both wrapping to 0; line SHALL increment when h wraps.
REQ-018 SHALL encode levels as {output_450ohm, output_900ohm}: 00 sync, 01 black, 10 grey, 11 white.
REQ-019 SHALL, on a normal line, output sync for h<HSYNC_CYCLES and black otherwise, except in the active region.
REQ-020 SHALL define the active region as an active line with ACTIVE_START <= h < ACTIVE_START+PIXELS*PIXEL_DIV.
REQ-021 SHALL, on a vsync line, output sync for h<LINE_CYCLES-HSYNC_CYCLES and black for the rest of the line.
REQ-022 SHALL pulse pixel_req, with pixel_x/pixel_y valid, once per pixel on the first clock of that pixel's counter window.
REQ-023 SHALL sample pixel_data one clock after pixel_req and hold the resulting level for exactly PIXEL_DIV output clocks.
REQ-024 SHALL map pixel_data 00 to black (01) so that active video never produces sync; SHALL pass 01/10/11 through unchanged.
REQ-025 SHALL register all outputs; DAC outputs and frame_start SHALL lag the counters by exactly 2 clocks, uniformly.
REQ-026 SHALL pulse frame_start together with the first output clock of line 0, h 0.
REQ-027 SHALL give vsync precedence if a line is both vsync and active: no pixel_req and no active video on that line.
REQ-028 SHALL, while enable is low, hold the counters at 0, pixel_req and frame_start at 0, and the DAC at black (01).
REQ-029 SHALL, when enable rises, start at h=0, line=0 on the next clock; frame_start SHALL follow 2 clocks later.
REQ-030 SHALL fail elaboration when PIXEL_DIV<1, when ACTIVE_START+PIXELS*PIXEL_DIV > LINE_CYCLES, when HSYNC_CYCLES >= ACTIVE_START, or when any line window exceeds LINES.

Reset
REQ-031 SHALL, while reset_n is low on a clock edge, set the counters to 0, DAC to black (01), and pixel_req, pixel_x, pixel_y and frame_start to 0.
REQ-032 SHALL abort the current line immediately on reset mid-line, including mid-pixel; no partial pixel SHALL be emitted after reset.
REQ-033 SHALL give reset priority over enable.

Configuration
REQ-034 SHALL, when macro VSYNC_SERRATION_EN is defined, split each vsync line into two half-lines of LINE_CYCLES/2 clocks.
REQ-035 SHALL, with VSYNC_SERRATION_EN, output per half-line sync for LINE_CYCLES/2-HSYNC_CYCLES clocks, then black for HSYNC_CYCLES clocks.
REQ-036 SHALL, with VSYNC_SERRATION_EN, require LINE_CYCLES to be even and fail elaboration otherwise.
REQ-037 SHALL, without VSYNC_SERRATION_EN, produce vsync lines exactly as in REQ-021.

Verification
REQ-038 SHALL cover defaults, enable=1, pixel_data=11 -> line 0: 127 clocks of 00, 173 of 01, 1416 of 01; line 20: 127 of 00, 173 of 01, 1280 of 11, 136 of 01.
REQ-039 SHALL cover defaults, lines 247-249 -> 1589 clocks of 00 then 127 of 01 per line; with VSYNC_SERRATION_EN -> (731 of 00, 127 of 01) twice per line.
REQ-040 SHALL cover defaults, a counter of pixel_req per frame -> 224*256 = 57344 pulses; pixel_x runs 0..255 and pixel_y runs 0..223.
REQ-041 SHALL cover pixel_data=00 in the active region -> outputs 01, never 00.
REQ-042 SHALL cover reset_n low for 1 clock at line 100, h 600 -> next outputs 01, counters 0, and frame_start 2 clocks after reset_n rises.
REQ-043 SHALL cover enable low for 50 clocks mid-frame -> outputs 01, no pixel_req, and restart at line 0 with a frame_start pulse.

Source files
------------

// File: rtl/composite_timing_gen.sv
// Composite video timing generator driving a two-resistor DAC.
//
// Walks an h counter (0..LINE_CYCLES-1) and a line counter (0..LINES-1), requests pixels from an
// external source during the active window and produces sync/black/grey/white levels on
// {output_450ohm, output_900ohm} = 00 sync, 01 black, 10 grey, 11 white.
//
// Pipeline: counters -> stage 1 (pixel_req/pixel_x/pixel_y, level decode) -> stage 2 (DAC,
// frame_start). DAC and frame_start therefore lag the counters by exactly two clocks; pixel_data
// is sampled on the clock after pixel_req and merged in at stage 2.
//
// Optional feature: define VSYNC_SERRATION_EN to split each vsync line into two serrated
// half-lines.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset (priority over enable)
//   enable         run the timing when high; low holds counters at 0 and the DAC at black
//   pixel_data     level of the requested pixel, valid the clock after pixel_req
//   pixel_req      one-cycle request for the pixel at (pixel_x, pixel_y)
//   pixel_x/y      coordinates of the requested pixel
//   output_450ohm  DAC MSB
//   output_900ohm  DAC LSB
//   frame_start    one-cycle marker on the first output clock of line 0, h 0
module composite_timing_gen #(
  parameter int unsigned LINE_CYCLES       = 1716,
  parameter int unsigned HSYNC_CYCLES      = 127,
  parameter int unsigned ACTIVE_START      = 300,
  parameter int unsigned PIXELS            = 256,
  parameter int unsigned PIXEL_DIV         = 5,
  parameter int unsigned LINES             = 262,
  parameter int unsigned ACTIVE_LINE_START = 20,
  parameter int unsigned ACTIVE_LINES      = 224,
  parameter int unsigned VSYNC_START       = 247,
  parameter int unsigned VSYNC_LINES       = 3,
  localparam int unsigned XW = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int unsigned YW = (ACTIVE_LINES > 1) ? $clog2(ACTIVE_LINES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    pixel_data,
  output logic          pixel_req,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          output_450ohm,
  output logic          output_900ohm,
  output logic          frame_start
);

  localparam int unsigned HW = $clog2(LINE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LINES + 1);
  localparam int unsigned DW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam int unsigned ACTIVE_END = ACTIVE_START + PIXELS * PIXEL_DIV;

  localparam logic [1:0] LvlSync  = 2'b00;
  localparam logic [1:0] LvlBlack = 2'b01;

  // Elaboration-time parameter checks.
  if (PIXEL_DIV == 0) begin : g_bad_div
    $error("PIXEL_DIV must be at least 1");
  end
  if (ACTIVE_END > LINE_CYCLES) begin : g_bad_hwin
    $error("active window extends past the end of the line");
  end
  if (HSYNC_CYCLES >= ACTIVE_START) begin : g_bad_hsync
    $error("HSYNC_CYCLES must be below ACTIVE_START");
  end
  if (ACTIVE_LINE_START + ACTIVE_LINES > LINES) begin : g_bad_awin
    $error("active line window exceeds LINES");
  end
  if (VSYNC_START + VSYNC_LINES > LINES) begin : g_bad_vwin
    $error("vsync line window exceeds LINES");
  end
`ifdef VSYNC_SERRATION_EN
  if (LINE_CYCLES % 2 != 0) begin : g_bad_half
    $error("VSYNC_SERRATION_EN requires an even LINE_CYCLES");
  end
`endif

  // Counters
  logic [HW-1:0] h_q, h_d;
  logic [LW-1:0] line_q, line_d;
  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] px_q, px_d;
  // Stage 1
  logic          req_q, req_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    s1_level_q, s1_level_d;
  logic          s1_first_q, s1_first_d;
  logic          s1_hold_q, s1_hold_d;
  logic          s1_frame_q, s1_frame_d;
  // Stage 2
  logic [1:0]    dac_q, dac_d;
  logic [1:0]    pix_q, pix_d;
  logic          frame_q, frame_d;

  logic       run;
  logic       h_wrap, in_win, vs_line, act_line;
  logic [1:0] pix_level;
`ifdef VSYNC_SERRATION_EN
  logic [HW-1:0] hh;
`endif

  assign run      = reset_n & enable;
  assign h_wrap   = (h_q == HW'(LINE_CYCLES - 1));
  assign in_win   = (h_q >= HW'(ACTIVE_START)) && (h_q < HW'(ACTIVE_END));
  assign vs_line  = (line_q >= LW'(VSYNC_START)) && (line_q < LW'(VSYNC_START + VSYNC_LINES));
  assign act_line = (line_q >= LW'(ACTIVE_LINE_START)) &&
                    (line_q < LW'(ACTIVE_LINE_START + ACTIVE_LINES));
  // Active video never drives sync: a zero pixel becomes black.
  assign pix_level = (pixel_data == 2'b00) ? LvlBlack : pixel_data;

  // Counter next state
  always_comb begin
    h_d    = '0;
    line_d = '0;
    div_d  = '0;
    px_d   = '0;
    if (run) begin
      h_d    = h_wrap ? '0 : h_q + 1'b1;
      line_d = line_q;
      div_d  = div_q;
      px_d   = px_q;
      if (h_wrap) begin
        line_d = (line_q == LW'(LINES - 1)) ? '0 : line_q + 1'b1;
        div_d  = '0;
        px_d   = '0;
      end else if (in_win) begin
        if (div_q == DW'(PIXEL_DIV - 1)) begin
          div_d = '0;
          px_d  = px_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  // Stage 1: decode the level for the current counter position
  always_comb begin
    s1_level_d = LvlBlack;
    s1_first_d = 1'b0;
    s1_hold_d  = 1'b0;
    s1_frame_d = 1'b0;
    req_d      = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
`ifdef VSYNC_SERRATION_EN
    hh = (h_q >= HW'(LINE_CYCLES / 2)) ? h_q - HW'(LINE_CYCLES / 2) : h_q;
`endif
    if (!run) begin
      x_d = '0;
      y_d = '0;
    end else begin
      s1_frame_d = (h_q == '0) && (line_q == '0);
      if (vs_line) begin
`ifdef VSYNC_SERRATION_EN
        s1_level_d = (hh < HW'(LINE_CYCLES / 2 - HSYNC_CYCLES)) ? LvlSync : LvlBlack;
`else
        s1_level_d = (h_q < HW'(LINE_CYCLES - HSYNC_CYCLES)) ? LvlSync : LvlBlack;
`endif
      end else if (act_line && in_win) begin
        s1_first_d = (div_q == '0);
        s1_hold_d  = (div_q != '0);
        req_d      = (div_q == '0);
        if (div_q == '0) begin
          x_d = px_q;
          y_d = YW'(line_q - LW'(ACTIVE_LINE_START));
        end
      end else begin
        s1_level_d = (h_q < HW'(HSYNC_CYCLES)) ? LvlSync : LvlBlack;
      end
    end
  end

  // Stage 2: merge the sampled pixel level; enable/reset force black at once
  always_comb begin
    dac_d   = LvlBlack;
    pix_d   = pix_q;
    frame_d = 1'b0;
    if (run) begin
      frame_d = s1_frame_q;
      if (s1_first_q) begin
        dac_d = pix_level;
        pix_d = pix_level;
      end else if (s1_hold_q) begin
        dac_d = pix_q;
      end else begin
        dac_d = s1_level_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_q        <= '0;
      line_q     <= '0;
      div_q      <= '0;
      px_q       <= '0;
      req_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      s1_level_q <= LvlBlack;
      s1_first_q <= 1'b0;
      s1_hold_q  <= 1'b0;
      s1_frame_q <= 1'b0;
      dac_q      <= LvlBlack;
      pix_q      <= LvlBlack;
      frame_q    <= 1'b0;
    end else begin
      h_q        <= h_d;
      line_q     <= line_d;
      div_q      <= div_d;
      px_q       <= px_d;
      req_q      <= req_d;
      x_q        <= x_d;
      y_q        <= y_d;
      s1_level_q <= s1_level_d;
      s1_first_q <= s1_first_d;
      s1_hold_q  <= s1_hold_d;
      s1_frame_q <= s1_frame_d;
      dac_q      <= dac_d;
      pix_q      <= pix_d;
      frame_q    <= frame_d;
    end
  end

  assign pixel_req     = req_q;
  assign pixel_x       = x_q;
  assign pixel_y       = y_q;
  assign output_450ohm = dac_q[1];
  assign output_900ohm = dac_q[0];
  assign frame_start   = frame_q;

endmodule
